npu_stream_s2mm: RTL and testbench

- Stream-to-memory writer: consumes the NPU result stream (m_axis side of npu_top) and writes each beat into DRAM through the npu dram_* word interface.
- Acts as stream receiver and DRAM initiator, the opposite end of the npu_top output stream.
- Software arms it with a base address and word limit. One packet (terminated by tlast) is stored per arm. Completion is reported with a done pulse and a word count.

---
 rtl/npu_stream_s2mm.sv | 141 ++++++++++++++
 tb/tb_npu_stream_s2mm.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_stream_s2mm.sv
// Stream-to-memory writer: stores one tlast-terminated packet per arm into DRAM words.
// Optional irq/irq_clear ports are enabled by defining NPU_S2MM_IRQ_EN.
module npu_stream_s2mm #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [CNT_WIDTH-1:0]  cfg_max_words,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  output logic [DATA_WIDTH-1:0] dram_wdata,
  output logic                  dram_we,
  output logic                  dram_ce,
  input  logic                  dram_ready,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  overflow
`ifdef NPU_S2MM_IRQ_EN
  ,
  input  logic                  irq_clear,
  output logic                  irq
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CNT_WIDTH-1:0]  r_limit;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_overflow;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_last;
  logic                  w_accept;
  logic                  w_wr_done;
  logic                  w_room;

  assign w_accept  = s_axis_tvalid & s_axis_tready;
  assign w_wr_done = dram_ce & dram_we & dram_ready;
  assign w_room    = (r_count < r_limit);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cfg_start) w_next = S_RECV;
      S_RECV: begin
        if (w_accept) begin
          if (w_room)            w_next = S_WRITE;
          else if (s_axis_tlast) w_next = S_DONE;
          else                   w_next = S_DRAIN;
        end
      end
      S_WRITE: if (w_wr_done) w_next = r_last ? S_DONE : S_RECV;
      S_DRAIN: if (w_accept && s_axis_tlast) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ce/we follow the WRITE state, so reset or completion drops them on the next edge.
  always_comb begin
    s_axis_tready = 1'b0;
    dram_ce       = 1'b0;
    dram_we       = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (r_state)
      S_RECV:  begin s_axis_tready = 1'b1; busy = 1'b1; end
      S_WRITE: begin dram_ce = 1'b1; dram_we = 1'b1; busy = 1'b1; end
      S_DRAIN: begin s_axis_tready = 1'b1; busy = 1'b1; end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base     <= '0;
      r_limit    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_last     <= 1'b0;
    end else begin
      if (r_state == S_IDLE && cfg_start) begin
        r_base     <= cfg_base_addr;
        r_limit    <= cfg_max_words;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end
      if (r_state == S_RECV && w_accept) begin
        if (w_room) begin
          r_wdata <= s_axis_tdata;
          r_addr  <= r_base + ADDR_WIDTH'(r_count);
          r_last  <= s_axis_tlast;
        end else begin
          r_overflow <= 1'b1;
        end
      end
      if (r_state == S_WRITE && w_wr_done) r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign dram_addr  = r_addr;
  assign dram_wdata = r_wdata;
  assign word_count = r_count;
  assign overflow   = r_overflow;

`ifdef NPU_S2MM_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk) begin
    if (rst)            r_irq <= 1'b0;
    else if (done)      r_irq <= 1'b1;
    else if (irq_clear) r_irq <= 1'b0;
  end
  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_npu_stream_s2mm.sv
// Directed bench for npu_stream_s2mm: cycle table for a clean packet plus stall/overflow/wrap/reset sequences.
module tb_npu_stream_s2mm;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start;
  logic [AW-1:0] cfg_base_addr;
  logic [CW-1:0] cfg_max_words;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [AW-1:0] dram_addr;
  logic [DW-1:0] dram_wdata;
  logic          dram_we;
  logic          dram_ce;
  logic          dram_ready;
  logic          busy;
  logic          done;
  logic [CW-1:0] word_count;
  logic          overflow;
`ifdef NPU_S2MM_IRQ_EN
  logic          irq_clear;
  logic          irq;
`endif

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;

  always #5 clk = ~clk;

  npu_stream_s2mm #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_max_words(cfg_max_words), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .dram_addr(dram_addr),
    .dram_wdata(dram_wdata), .dram_we(dram_we), .dram_ce(dram_ce), .dram_ready(dram_ready),
    .busy(busy), .done(done), .word_count(word_count), .overflow(overflow)
`ifdef NPU_S2MM_IRQ_EN
    , .irq_clear(irq_clear), .irq(irq)
`endif
  );

  always @(posedge clk) if (!rst && dram_ce && dram_we && dram_ready) wr_cnt <= wr_cnt + 1;

  typedef struct {
    logic          start, valid, last, ready;
    logic [DW-1:0] data;
    logic          e_tready, e_ce, e_busy, e_done, e_ovf;
    logic [CW-1:0] e_cnt;
    logic          chk_aw;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic v, input logic [DW-1:0] d, input logic l,
                              input logic tr, input logic ce, input logic bz, input logic dn,
                              input logic [CW-1:0] c, input logic aw, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd);
    vec_t r;
    r.start = st; r.valid = v; r.data = d; r.last = l; r.ready = 1'b1;
    r.e_tready = tr; r.e_ce = ce; r.e_busy = bz; r.e_done = dn; r.e_ovf = 1'b0;
    r.e_cnt = c; r.chk_aw = aw; r.e_addr = a; r.e_wdata = wd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [AW-1:0] base, input logic [CW-1:0] lim);
    cfg_base_addr = base; cfg_max_words = lim; cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    chk("arm_busy", busy, 1);
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic l, input logic wr,
                      input logic [AW-1:0] a, input int stall);
    int n = 0;
    while (!s_axis_tready && n < 10) begin tick; n++; end
    chk("beat_tready", s_axis_tready, 1);
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = l;
    tick;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    if (wr) begin
      for (int i = 0; i <= stall; i++) begin
        dram_ready = (i == stall);
        chk("wr_hold", {dram_ce, dram_we, s_axis_tready, dram_addr, dram_wdata},
            {1'b1, 1'b1, 1'b0, a, d});
        tick;
      end
    end else begin
      chk("discard_no_ce", {dram_ce, dram_we}, 2'b00);
    end
  endtask

  task automatic fin(input logic [CW-1:0] cnt, input logic ovf);
    chk("done_pulse", {done, busy, word_count, overflow}, {1'b1, 1'b0, cnt, ovf});
    tick;
    chk("done_gone", {done, busy, word_count}, {1'b0, 1'b0, cnt});
  endtask

  vec_t tbl[11];
  int   w0;

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_base_addr = '0; cfg_max_words = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; dram_ready = 1'b1;
`ifdef NPU_S2MM_IRQ_EN
    irq_clear = 1'b0;
`endif
    tick; tick;
    chk("reset_ctl", {s_axis_tready, dram_ce, dram_we, busy, done, overflow, word_count}, '0);
    chk("reset_bus", {dram_addr, dram_wdata}, '0);
`ifdef NPU_S2MM_IRQ_EN
    chk("reset_irq", irq, 0);
`endif
    rst = 1'b0;

    // tvalid while idle must stay pending
    s_axis_tvalid = 1'b1; s_axis_tdata = 16'hDEAD;
    tick; tick;
    chk("idle_tvalid", {s_axis_tready, busy, dram_ce}, 3'b000);
    chk("idle_no_write", wr_cnt, 0);
    s_axis_tvalid = 1'b0;

    // clean 4-beat packet, one row per cycle
    tbl[0]  = mk(1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 32'h0,   16'h0);
    tbl[1]  = mk(0, 1, 16'h1234, 0, 1, 0, 1, 0, 0, 0, 32'h0,   16'h0);
    tbl[2]  = mk(0, 1, 16'h5678, 0, 0, 1, 1, 0, 0, 1, 32'h100, 16'h1234);
    tbl[3]  = mk(0, 1, 16'h5678, 0, 1, 0, 1, 0, 1, 0, 32'h0,   16'h0);
    tbl[4]  = mk(0, 1, 16'hAAAA, 0, 0, 1, 1, 0, 1, 1, 32'h101, 16'h5678);
    tbl[5]  = mk(0, 1, 16'hAAAA, 0, 1, 0, 1, 0, 2, 0, 32'h0,   16'h0);
    tbl[6]  = mk(0, 1, 16'h5555, 1, 0, 1, 1, 0, 2, 1, 32'h102, 16'hAAAA);
    tbl[7]  = mk(0, 1, 16'h5555, 1, 1, 0, 1, 0, 3, 0, 32'h0,   16'h0);
    tbl[8]  = mk(0, 0, 16'h0000, 0, 0, 1, 1, 0, 3, 1, 32'h103, 16'h5555);
    tbl[9]  = mk(0, 0, 16'h0000, 0, 0, 0, 0, 1, 4, 0, 32'h0,   16'h0);
    tbl[10] = mk(0, 0, 16'h0000, 0, 0, 0, 0, 0, 4, 0, 32'h0,   16'h0);
    cfg_base_addr = 32'h100; cfg_max_words = 16'd4;
    w0 = wr_cnt;
    for (int i = 0; i < 11; i++) begin
      cfg_start = tbl[i].start; s_axis_tvalid = tbl[i].valid; s_axis_tdata = tbl[i].data;
      s_axis_tlast = tbl[i].last; dram_ready = tbl[i].ready;
      chk($sformatf("row%0d_ctl", i),
          {s_axis_tready, dram_ce, dram_we, busy, done, overflow, word_count},
          {tbl[i].e_tready, tbl[i].e_ce, tbl[i].e_ce, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_ovf, tbl[i].e_cnt});
      if (tbl[i].chk_aw)
        chk($sformatf("row%0d_bus", i), {dram_addr, dram_wdata}, {tbl[i].e_addr, tbl[i].e_wdata});
      tick;
    end
    cfg_start = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    chk("t1_writes", wr_cnt - w0, 4);

    // same packet with a 3-cycle stall on the second write
    w0 = wr_cnt;
    arm(32'h100, 16'd4);
    beat(16'h1234, 0, 1, 32'h100, 0);
    beat(16'h5678, 0, 1, 32'h101, 3);
    beat(16'hAAAA, 0, 1, 32'h102, 0);
    beat(16'h5555, 1, 1, 32'h103, 0);
    chk("t2_writes", wr_cnt - w0, 4);
    fin(16'd4, 1'b0);

    // limit 2 with a 5-beat packet; cfg_start during DONE is ignored
    w0 = wr_cnt;
    arm(32'h100, 16'd2);
    beat(16'h0001, 0, 1, 32'h100, 0);
    beat(16'h0002, 0, 1, 32'h101, 0);
    beat(16'h0003, 0, 0, 32'h0, 0);
    chk("t3_ovf_set", {overflow, busy}, 2'b11);
    beat(16'h0004, 0, 0, 32'h0, 0);
    beat(16'h0005, 1, 0, 32'h0, 0);
    chk("t3_writes", wr_cnt - w0, 2);
    chk("t3_done", {done, busy, word_count, overflow}, {1'b1, 1'b0, 16'd2, 1'b1});
    cfg_base_addr = 32'h900; cfg_max_words = 16'd7; cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    chk("t3_start_in_done", {busy, done, word_count, overflow}, {1'b0, 1'b0, 16'd2, 1'b1});

    // limit 0
    w0 = wr_cnt;
    arm(32'h100, 16'd0);
    chk("t4_ovf_cleared", overflow, 0);
    beat(16'h7777, 1, 0, 32'h0, 0);
    chk("t4_writes", wr_cnt - w0, 0);
    fin(16'd0, 1'b1);

    // address wrap, and re-arm attempt while busy
    arm(32'hFFFF_FFFF, 16'd4);
    cfg_base_addr = 32'h500; cfg_max_words = 16'd1; cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    beat(16'h1111, 0, 1, 32'hFFFF_FFFF, 0);
    beat(16'h2222, 1, 1, 32'h0000_0000, 1);
    fin(16'd2, 1'b0);
`ifdef NPU_S2MM_IRQ_EN
    chk("irq_set", irq, 1);
    tick;
    chk("irq_hold", irq, 1);
    irq_clear = 1'b1;
    tick;
    irq_clear = 1'b0;
    chk("irq_clear", irq, 0);
`endif

    // reset while a write is stalled
    arm(32'h200, 16'd4);
    s_axis_tvalid = 1'b1; s_axis_tdata = 16'hBEEF; s_axis_tlast = 1'b1;
    tick;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; dram_ready = 1'b0;
    chk("t6_in_write", {dram_ce, dram_addr}, {1'b1, 32'h200});
    rst = 1'b1;
    tick;
    rst = 1'b0; dram_ready = 1'b1;
    chk("t6_after_rst", {dram_ce, dram_we, busy, done, s_axis_tready, word_count}, '0);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
        seen = seen | done | dram_ce;
        tick;
      end
      chk("t6_no_done", seen, 0);
    end
    arm(32'h300, 16'd2);
    beat(16'h4321, 1, 1, 32'h300, 0);
    fin(16'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
